// File: rtl/regfile_arbiter_pkg.sv
// rtl/regfile_arbiter_pkg.sv - shared sizes, scan states and requester ids for the register file arbiter
//
// Purpose: constants and enums used by regfile_arbiter and regfile_scan_engine.
// Ports: none (package).

package regfile_arbiter_pkg;

  localparam int NREGS        = 64;
  localparam int WIDTH        = 32;
  localparam int AW           = $clog2(NREGS);
  localparam int STARVE_LIMIT = 8;
  localparam int STARVE_W     = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {
    SCAN_IDLE = 2'd0,
    SCAN_RUN  = 2'd1,
    SCAN_DONE = 2'd2
  } scan_state_e;

  // Owner of the single access slot; REQ_NONE marks an idle slot.
  typedef enum logic [1:0] {
    REQ_CPU  = 2'd0,
    REQ_HOST = 2'd1,
    REQ_SCAN = 2'd2,
    REQ_NONE = 2'd3
  } req_id_e;

endpackage

// File: rtl/regfile_arbiter_scan_engine.sv
// rtl/regfile_arbiter_scan_engine.sv - max-value scan FSM with starvation counter
//
// Purpose: walks registers 0..NREGS-1 through the shared access slot and keeps
//   the signed maximum of the values read.
// Ports:
//   clk, reset     clock, synchronous active-low reset
//   scan_start     pulse, accepted only in IDLE
//   scan_gnt       slot granted to the scan this cycle
//   scan_rdata     register contents at scan_addr (current cycle)
//   scan_req       scan wants the slot
//   scan_force     starvation limit reached, slot must go to the scan
//   scan_addr      register index being scanned
//   scan_busy      RUN state
//   scan_done      one-cycle pulse in DONE state
//   scan_max       signed maximum, held until the next run reloads it

module regfile_scan_engine
  import regfile_arbiter_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    scan_start,
  input  logic                    scan_gnt,
  input  logic signed [WIDTH-1:0] scan_rdata,
  output logic                    scan_req,
  output logic                    scan_force,
  output logic [AW-1:0]           scan_addr,
  output logic                    scan_busy,
  output logic                    scan_done,
  output logic signed [WIDTH-1:0] scan_max
);

  scan_state_e             state_q, state_d;
  logic [AW-1:0]           idx_q, idx_d;
  logic signed [WIDTH-1:0] max_q, max_d;
  logic [STARVE_W-1:0]     starve_q, starve_d;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= SCAN_IDLE;
      idx_q    <= '0;
      max_q    <= '0;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      max_q    <= max_d;
      starve_q <= starve_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    max_d    = max_q;
    starve_d = starve_q;
    unique case (state_q)
      SCAN_IDLE: begin
        if (scan_start) begin
          state_d = SCAN_RUN;
          idx_d   = '0;
        end
      end
      SCAN_RUN: begin
        if (scan_gnt) begin
          // First read seeds the maximum so stale results never leak in.
          if (idx_q == '0 || scan_rdata > max_q) max_d = scan_rdata;
          idx_d = idx_q + AW'(1);
          if (idx_q == AW'(NREGS - 1)) state_d = SCAN_DONE;
        end
      end
      SCAN_DONE: state_d = SCAN_IDLE;
      default:   state_d = SCAN_IDLE;
    endcase

    // Counts lost slots while the scan waits; saturates at the limit.
    if (state_q != SCAN_RUN || scan_gnt) begin
      starve_d = '0;
    end else if (starve_q != STARVE_W'(STARVE_LIMIT)) begin
      starve_d = starve_q + STARVE_W'(1);
    end
  end

  assign scan_req   = (state_q == SCAN_RUN);
  assign scan_force = scan_req && (starve_q == STARVE_W'(STARVE_LIMIT));
  assign scan_addr  = idx_q;
  assign scan_busy  = (state_q == SCAN_RUN);
  assign scan_done  = (state_q == SCAN_DONE);
  assign scan_max   = max_q;

endmodule

// File: rtl/regfile_arbiter.sv
// rtl/regfile_arbiter.sv - 64x32 signed register file with cpu/host/scan slot arbitration
//
// Purpose: single-access-per-cycle register file shared by a cpu (read/write
//   with RMW lock), a host (read-only) and an internal max-scan engine.
// Ports:
//   clk, reset                  clock, synchronous active-low reset
//   cpu_req/lock/we/addr/wdata  cpu request; lock holds the slot next cycle
//   cpu_gnt                     cpu access performed this cycle (combinational)
//   cpu_rdata/cpu_rvalid        read data one cycle after a granted read
//   host_req/host_addr          host read request
//   host_gnt                    host read performed this cycle (combinational)
//   host_rdata/host_rvalid      read data one cycle after a granted read
//   scan_start                  start a max scan (ignored while busy)
//   scan_busy/done/max          scan status and signed result

module regfile_arbiter
  import regfile_arbiter_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cpu_req,
  input  logic                    cpu_lock,
  input  logic                    cpu_we,
  input  logic [AW-1:0]           cpu_addr,
  input  logic signed [WIDTH-1:0] cpu_wdata,
  output logic                    cpu_gnt,
  output logic signed [WIDTH-1:0] cpu_rdata,
  output logic                    cpu_rvalid,
  input  logic                    host_req,
  input  logic [AW-1:0]           host_addr,
  output logic                    host_gnt,
  output logic signed [WIDTH-1:0] host_rdata,
  output logic                    host_rvalid,
  input  logic                    scan_start,
  output logic                    scan_busy,
  output logic                    scan_done,
  output logic signed [WIDTH-1:0] scan_max
);

  logic signed [WIDTH-1:0] regs_q [NREGS];
  logic signed [WIDTH-1:0] regs_d [NREGS];
  req_id_e                 rr_q, rr_d, gnt_sel;
  logic                    lock_q, lock_d;
  logic signed [WIDTH-1:0] cpu_rdata_q, cpu_rdata_d, host_rdata_q, host_rdata_d;
  logic                    cpu_rvalid_q, cpu_rvalid_d, host_rvalid_q, host_rvalid_d;
  logic                    scan_req, scan_force, scan_gnt, locked;
  logic [AW-1:0]           scan_addr;

  regfile_scan_engine u_scan (
    .clk        (clk),
    .reset      (reset),
    .scan_start (scan_start),
    .scan_gnt   (scan_gnt),
    .scan_rdata (regs_q[scan_addr]),
    .scan_req   (scan_req),
    .scan_force (scan_force),
    .scan_addr  (scan_addr),
    .scan_busy  (scan_busy),
    .scan_done  (scan_done),
    .scan_max   (scan_max)
  );

  // Lock only survives while the cpu keeps both req and lock asserted.
  assign locked = lock_q && cpu_req && cpu_lock;

  // A starved scan outranks even a locked cpu, which breaks the lock.
  always_comb begin
    gnt_sel = REQ_NONE;
    if (reset) begin
      if (scan_force)                gnt_sel = REQ_SCAN;
      else if (locked)               gnt_sel = REQ_CPU;
      else if (cpu_req && host_req)  gnt_sel = rr_q;
      else if (cpu_req)              gnt_sel = REQ_CPU;
      else if (host_req)             gnt_sel = REQ_HOST;
      else if (scan_req)             gnt_sel = REQ_SCAN;
    end
  end

  assign cpu_gnt  = (gnt_sel == REQ_CPU);
  assign host_gnt = (gnt_sel == REQ_HOST);
  assign scan_gnt = (gnt_sel == REQ_SCAN);

  always_comb begin
    regs_d = regs_q;
    if (cpu_gnt && cpu_we) regs_d[cpu_addr] = cpu_wdata;

    rr_d = rr_q;
    if (cpu_gnt)       rr_d = REQ_HOST;
    else if (host_gnt) rr_d = REQ_CPU;

    lock_d = cpu_gnt && cpu_lock;

    cpu_rvalid_d  = cpu_gnt && !cpu_we;
    cpu_rdata_d   = cpu_rvalid_d ? regs_q[cpu_addr] : cpu_rdata_q;
    host_rvalid_d = host_gnt;
    host_rdata_d  = host_gnt ? regs_q[host_addr] : host_rdata_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      rr_q          <= REQ_CPU;
      lock_q        <= 1'b0;
      cpu_rdata_q   <= '0;
      cpu_rvalid_q  <= 1'b0;
      host_rdata_q  <= '0;
      host_rvalid_q <= 1'b0;
    end else begin
      regs_q        <= regs_d;
      rr_q          <= rr_d;
      lock_q        <= lock_d;
      cpu_rdata_q   <= cpu_rdata_d;
      cpu_rvalid_q  <= cpu_rvalid_d;
      host_rdata_q  <= host_rdata_d;
      host_rvalid_q <= host_rvalid_d;
    end
  end

  assign cpu_rdata   = cpu_rdata_q;
  assign cpu_rvalid  = cpu_rvalid_q;
  assign host_rdata  = host_rdata_q;
  assign host_rvalid = host_rvalid_q;

endmodule

// File: tb/tb_regfile_arbiter.sv
// tb/tb_regfile_arbiter.sv - directed self-checking bench for regfile_arbiter

module tb_regfile_arbiter;
  import regfile_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_lock, cpu_we;
  logic [5:0]  cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_gnt, cpu_rvalid;
  logic [31:0] cpu_rdata;
  logic        host_req;
  logic [5:0]  host_addr;
  logic        host_gnt, host_rvalid;
  logic [31:0] host_rdata;
  logic        scan_start, scan_busy, scan_done;
  logic [31:0] scan_max;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  regfile_arbiter dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_lock(cpu_lock), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_gnt(cpu_gnt), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
    .host_req(host_req), .host_addr(host_addr), .host_gnt(host_gnt),
    .host_rdata(host_rdata), .host_rvalid(host_rvalid),
    .scan_start(scan_start), .scan_busy(scan_busy), .scan_done(scan_done), .scan_max(scan_max)
  );

  typedef struct {
    logic        cr, cl, cw;
    logic [5:0]  ca;
    logic [31:0] cwd;
    logic        hr;
    logic [5:0]  ha;
    logic        e_cgnt, e_hgnt;
    logic [31:0] e_crd, e_hrd;
  } vec_t;

  vec_t vt [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cpu_req = 0; cpu_lock = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    host_req = 0; host_addr = 0; scan_start = 0;
  endtask

  task automatic do_reset();
    reset = 0;
    cyc(); cyc();
    reset = 1;
  endtask

  task automatic cpu_write(input logic [5:0] a, input logic [31:0] d);
    cpu_req = 1; cpu_we = 1; cpu_addr = a; cpu_wdata = d;
    cyc();
    cpu_req = 0; cpu_we = 0;
  endtask

  // Runs one scan; returns cycle on which scan_done is seen (start cycle = 0),
  // plus the cycles where a held host lost the slot to the scan.
  task automatic run_scan(input logic hold_host, output int n, output int gaps,
                          output int first_gap, output int bad_spacing);
    int last;
    scan_start = 1; host_req = hold_host; host_addr = 0;
    cyc();
    scan_start = 0;
    chk("scan_busy after start", scan_busy, 1);
    n = 1; gaps = 0; first_gap = 0; bad_spacing = 0; last = 0;
    while (scan_done !== 1'b1 && n < 2000) begin
      scan_start = (n == 30);
      @(negedge clk);
      if (hold_host && scan_busy && !host_gnt) begin
        gaps++;
        if (first_gap == 0) first_gap = n;
        else if (n - last != STARVE_LIMIT + 1) bad_spacing++;
        last = n;
      end
      cyc();
      n++;
    end
    scan_start = 0; host_req = 0;
  endtask

  initial begin
    int n, gaps, first_gap, bad, seen;

    // --- reset with all requests asserted: every output must be 0
    idle();
    cpu_req = 1; host_req = 1; scan_start = 1; cpu_we = 1; cpu_wdata = 32'h55;
    reset = 0;
    cyc(); cyc();
    @(negedge clk);
    chk("rst cpu_gnt", cpu_gnt, 0);
    chk("rst host_gnt", host_gnt, 0);
    chk("rst cpu_rvalid", cpu_rvalid, 0);
    chk("rst cpu_rdata", cpu_rdata, 0);
    chk("rst host_rvalid", host_rvalid, 0);
    chk("rst host_rdata", host_rdata, 0);
    chk("rst scan_busy", scan_busy, 0);
    chk("rst scan_done", scan_done, 0);
    chk("rst scan_max", scan_max, 0);
    idle();
    cyc();
    reset = 1;

    // --- host reads r5 after reset
    host_req = 1; host_addr = 5;
    @(negedge clk);
    chk("t1 host_gnt", host_gnt, 1);
    cyc();
    host_req = 0;
    chk("t1 host_rvalid", host_rvalid, 1);
    chk("t1 host_rdata", host_rdata, 0);

    // --- table: round robin, locked RMW, lock release
    vt[0]  = '{1,0,1,6'd1,32'h11, 0,6'd0, 1,0, 32'h0, 32'h0};
    vt[1]  = '{1,0,0,6'd1,32'h0,  1,6'd1, 0,1, 32'h0, 32'h11};
    vt[2]  = '{1,0,0,6'd1,32'h0,  1,6'd1, 1,0, 32'h11,32'h0};
    vt[3]  = '{1,0,0,6'd1,32'h0,  1,6'd1, 0,1, 32'h0, 32'h11};
    vt[4]  = '{1,0,0,6'd1,32'h0,  1,6'd1, 1,0, 32'h11,32'h0};
    vt[5]  = '{1,0,0,6'd1,32'h0,  1,6'd1, 0,1, 32'h0, 32'h11};
    vt[6]  = '{1,1,0,6'd3,32'h0,  1,6'd5, 1,0, 32'h0, 32'h0};
    vt[7]  = '{1,1,1,6'd3,32'h7,  1,6'd5, 1,0, 32'h0, 32'h0};
    vt[8]  = '{0,0,0,6'd0,32'h0,  1,6'd3, 0,1, 32'h0, 32'h7};
    vt[9]  = '{1,0,0,6'd3,32'h0,  0,6'd0, 1,0, 32'h7, 32'h0};
    vt[10] = '{1,1,0,6'd1,32'h0,  1,6'd1, 0,1, 32'h0, 32'h11};
    vt[11] = '{1,1,0,6'd1,32'h0,  1,6'd1, 1,0, 32'h11,32'h0};
    vt[12] = '{1,0,0,6'd1,32'h0,  1,6'd1, 0,1, 32'h0, 32'h11};

    for (int i = 0; i < 13; i++) begin
      cpu_req = vt[i].cr; cpu_lock = vt[i].cl; cpu_we = vt[i].cw;
      cpu_addr = vt[i].ca; cpu_wdata = vt[i].cwd;
      host_req = vt[i].hr; host_addr = vt[i].ha;
      @(negedge clk);
      chk($sformatf("v%0d cpu_gnt", i), cpu_gnt, vt[i].e_cgnt);
      chk($sformatf("v%0d host_gnt", i), host_gnt, vt[i].e_hgnt);
      cyc();
      chk($sformatf("v%0d cpu_rvalid", i), cpu_rvalid, vt[i].e_cgnt & ~vt[i].cw);
      if (vt[i].e_cgnt && !vt[i].cw)
        chk($sformatf("v%0d cpu_rdata", i), cpu_rdata, vt[i].e_crd);
      chk($sformatf("v%0d host_rvalid", i), host_rvalid, vt[i].e_hgnt);
      if (vt[i].e_hgnt)
        chk($sformatf("v%0d host_rdata", i), host_rdata, vt[i].e_hrd);
    end
    idle();

    // --- uncontended scan over r10=-5, r40=123, r63=-2^31, others 0
    do_reset();
    cpu_write(6'd10, 32'hFFFF_FFFB);
    cpu_write(6'd40, 32'd123);
    cpu_write(6'd63, 32'h8000_0000);
    run_scan(1'b0, n, gaps, first_gap, bad);
    chk("t4 done latency", n, 65);
    chk("t4 scan_max", scan_max, 32'd123);
    chk("t4 busy low in done", scan_busy, 0);
    cyc();
    chk("t4 done one pulse", scan_done, 0);
    repeat (3) cyc();
    chk("t4 scan_max held", scan_max, 32'd123);

    // --- all -3, host hogging the slot: scan forced every STARVE_LIMIT+1 cycles
    for (int a = 0; a < NREGS; a++) cpu_write(a[5:0], 32'hFFFF_FFFD);
    run_scan(1'b1, n, gaps, first_gap, bad);
    chk("t5 done latency", n, NREGS * (STARVE_LIMIT + 1) + 1);
    chk("t5 scan reads", gaps, NREGS);
    chk("t5 first forced", first_gap, STARVE_LIMIT + 1);
    chk("t5 spacing errors", bad, 0);
    chk("t5 scan_max", scan_max, 32'hFFFF_FFFD);
    cyc();

    // --- reset at scan idx 20 aborts; rerun on zeroed registers
    scan_start = 1;
    cyc();
    scan_start = 0;
    repeat (20) cyc();
    seen = 0;
    reset = 0;
    repeat (3) begin
      cyc();
      if (scan_done === 1'b1) seen = 1;
    end
    reset = 1;
    repeat (70) begin
      cyc();
      if (scan_done === 1'b1) seen = 1;
    end
    chk("t6 no done after abort", seen, 0);
    chk("t6 busy cleared", scan_busy, 0);
    host_req = 1; host_addr = 20;
    cyc();
    host_req = 0;
    chk("t6 r20 zeroed", host_rdata, 0);
    run_scan(1'b0, n, gaps, first_gap, bad);
    chk("t6 rerun latency", n, 65);
    chk("t6 rerun scan_max", scan_max, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
